pwm_multi_channel_gen: RTL and testbench

Parametrised multi-channel PWM generator with per-channel duty control from increase/decrease pushbuttons. Supports edge-aligned and center-aligned counting. Duty updates are shadowed and applied only at period boundaries, so outputs stay glitch-free. Instantiated under the tt_um top wrapper, with channels driving uo_out and buttons taken from ui_in/uio_in.

---
 rtl/pwm_pkg.sv | 37 +++
 rtl/pwm_button_sync.sv | 27 ++
 rtl/pwm_multi_channel_gen.sv | 118 +++++++++++
 tb/tb_pwm_multi_channel_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and duty arithmetic for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Working width for duty arithmetic; covers counter widths up to 16 bits.
  localparam int unsigned SAT_W = 17;

  // Half of full scale for a given counter width (the reset duty).
  function automatic int unsigned half_scale(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned RST_DUTY_DEF = half_scale(DEF_CNT_W);

  // Saturating step: clamps at max going up, at zero going down.
  function automatic logic [SAT_W-1:0] sat_step(
    input logic [SAT_W-1:0] duty,
    input logic [SAT_W-1:0] step,
    input logic [SAT_W-1:0] max,
    input logic             up
  );
    logic [SAT_W-1:0] res;
    if (up) begin
      res = duty + step;
      if (res > max) res = max;
    end else begin
      res = (step > duty) ? '0 : duty - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_button_sync.sv
// Two-flop synchroniser for an asynchronous button level plus rising-edge pulse.
module pwm_button_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse_c
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse_c = sync & ~prev;

endmodule

// File: rtl/pwm_multi_channel_gen.sv
// Multi-channel PWM with button-driven duty, edge/center counting and
// duty/mode changes deferred to period boundaries.
module pwm_multi_channel_gen
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned STEP  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            center_mode,
  input  logic [N_CH-1:0] inc_duty,
  input  logic [N_CH-1:0] dec_duty,
  output logic [N_CH-1:0] pwm_out,
  output logic            period_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(half_scale(CNT_W));

  logic [CNT_W-1:0] cnt;
  logic             dir_up;
  pwm_mode_e        mode_act;
  pwm_mode_e        mode_req;
  logic [CNT_W-1:0] duty_shadow [N_CH];
  logic [CNT_W-1:0] duty_act    [N_CH];
  logic [N_CH-1:0]  inc_pulse_c;
  logic [N_CH-1:0]  dec_pulse_c;
  logic             boundary_c;

  for (genvar g = 0; g < N_CH; g++) begin : g_btn
    pwm_button_sync u_inc (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (inc_duty[g]),
      .pulse_c (inc_pulse_c[g])
    );
    pwm_button_sync u_dec (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (dec_duty[g]),
      .pulse_c (dec_pulse_c[g])
    );
  end

  assign mode_req = pwm_mode_e'(center_mode);

  // Boundary: last edge-mode count, or bottom of the down-slope in center mode.
  always_comb begin
    boundary_c = 1'b0;
    if (ena) begin
      if (mode_act == PWM_EDGE) boundary_c = (cnt == CNT_MAX);
      else                      boundary_c = (cnt == '0) && !dir_up;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dir_up   <= 1'b1;
      mode_act <= PWM_EDGE;
    end else if (ena) begin
      if (boundary_c && (mode_req != mode_act)) begin
        cnt    <= '0;
        dir_up <= 1'b1;
      end else if (mode_act == PWM_EDGE) begin
        cnt    <= cnt + CNT_W'(1);
        dir_up <= 1'b1;
      end else if (dir_up) begin
        if (cnt == CNT_MAX) begin
          cnt    <= CNT_MAX - CNT_W'(1);
          dir_up <= 1'b0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (cnt == '0) begin
        cnt    <= CNT_W'(1);
        dir_up <= 1'b1;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
      if (boundary_c) mode_act <= mode_req;
    end
  end

  // Shadow duty follows button edges; active duty loads only at boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        duty_shadow[i] <= DUTY_RST;
        duty_act[i]    <= DUTY_RST;
      end
    end else if (ena) begin
      for (int i = 0; i < N_CH; i++) begin
        if (inc_pulse_c[i] && !dec_pulse_c[i])
          duty_shadow[i] <= CNT_W'(sat_step(SAT_W'(duty_shadow[i]), SAT_W'(STEP),
                                            SAT_W'(CNT_MAX), 1'b1));
        else if (dec_pulse_c[i] && !inc_pulse_c[i])
          duty_shadow[i] <= CNT_W'(sat_step(SAT_W'(duty_shadow[i]), SAT_W'(STEP),
                                            SAT_W'(CNT_MAX), 1'b0));
        if (boundary_c) duty_act[i] <= duty_shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) pwm_out[i] <= ena && (cnt < duty_act[i]);
      period_tick <= boundary_c;
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel_gen.sv
// Directed self-checking bench for pwm_multi_channel_gen (4 ch, 8-bit, step 16).
module tb_pwm_multi_channel_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       center_mode;
  logic [3:0] inc_duty;
  logic [3:0] dec_duty;
  logic [3:0] pwm_out;
  logic       period_tick;

  int checks = 0;
  int errors = 0;
  int m_len;
  int m_hi [4];

  pwm_multi_channel_gen #(.N_CH(4), .CNT_W(8), .STEP(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .center_mode (center_mode),
    .inc_duty    (inc_duty),
    .dec_duty    (dec_duty),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Window runs from one period_tick (exclusive) to the next (inclusive).
  task automatic measure();
    int n;
    n = 0;
    while (!period_tick && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("tick_timeout_start", 32'd0, 32'd1);
    m_len = 0;
    for (int i = 0; i < 4; i++) m_hi[i] = 0;
    do begin
      @(negedge clk);
      m_len++;
      for (int i = 0; i < 4; i++) m_hi[i] += int'(pwm_out[i]);
    end while (!period_tick && m_len < 2000);
    if (m_len >= 2000) chk("tick_timeout_end", 32'd0, 32'd1);
  endtask

  task automatic press(input logic [3:0] inc_m, input logic [3:0] dec_m);
    @(negedge clk);
    inc_duty = inc_m;
    dec_duty = dec_m;
    repeat (4) @(negedge clk);
    inc_duty = '0;
    dec_duty = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; center_mode = 1'b0;
    inc_duty = '0; dec_duty = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    chk("rst_cnt", 32'(dut.cnt), 32'd0);
    chk("rst_shadow0", 32'(dut.duty_shadow[0]), 32'd128);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Default 50% in edge mode
    measure();
    chk("edge_len", 32'(m_len), 32'd256);
    for (int i = 0; i < 4; i++) chk("edge_hi_default", 32'(m_hi[i]), 32'd128);

    // Single held press on inc ch1, two-edge latency, one step only
    repeat (20) @(negedge clk);
    inc_duty[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("inc1_lat_k1", 32'(dut.duty_shadow[1]), 32'd128);
    @(posedge clk);
    #1 chk("inc1_lat_k2", 32'(dut.duty_shadow[1]), 32'd144);
    repeat (48) @(negedge clk);
    chk("inc1_held_once", 32'(dut.duty_shadow[1]), 32'd144);
    chk("inc1_act_deferred", 32'(dut.duty_act[1]), 32'd128);
    inc_duty[1] = 1'b0;
    measure();
    chk("inc1_len", 32'(m_len), 32'd256);
    chk("inc1_hi1", 32'(m_hi[1]), 32'd144);
    chk("inc1_hi0", 32'(m_hi[0]), 32'd128);
    chk("inc1_hi2", 32'(m_hi[2]), 32'd128);

    // Saturation down on ch0, up on ch2, cancelling press on ch3
    for (int p = 0; p < 8; p++) press(4'b0000, 4'b0001);
    chk("dec0_sat8", 32'(dut.duty_shadow[0]), 32'd0);
    press(4'b0000, 4'b0001);
    chk("dec0_nowrap", 32'(dut.duty_shadow[0]), 32'd0);
    for (int p = 0; p < 7; p++) press(4'b0100, 4'b0000);
    chk("inc2_7", 32'(dut.duty_shadow[2]), 32'd240);
    press(4'b0100, 4'b0000);
    chk("inc2_sat", 32'(dut.duty_shadow[2]), 32'd255);
    press(4'b1000, 4'b1000);
    chk("both3_nochange", 32'(dut.duty_shadow[3]), 32'd128);
    measure();
    measure();
    chk("sat_len", 32'(m_len), 32'd256);
    chk("sat_hi0", 32'(m_hi[0]), 32'd0);
    chk("sat_hi1", 32'(m_hi[1]), 32'd144);
    chk("sat_hi2", 32'(m_hi[2]), 32'd255);
    chk("sat_hi3", 32'(m_hi[3]), 32'd128);

    // Ch3 to 64, then request center mode mid-period
    for (int p = 0; p < 4; p++) press(4'b0000, 4'b1000);
    chk("dec3_64", 32'(dut.duty_shadow[3]), 32'd64);
    measure();
    repeat (10) @(negedge clk);
    center_mode = 1'b1;
    @(negedge clk);
    chk("mode_deferred", 32'(dut.mode_act), 32'd0);
    measure();
    chk("center_first_len", 32'(m_len), 32'd511);
    measure();
    chk("center_len", 32'(m_len), 32'd510);
    chk("center_hi0", 32'(m_hi[0]), 32'd0);
    chk("center_hi1", 32'(m_hi[1]), 32'd287);
    chk("center_hi2", 32'(m_hi[2]), 32'd509);
    chk("center_hi3", 32'(m_hi[3]), 32'd127);

    // Pause: outputs low, counter frozen, presses ignored, no edge on resume
    repeat (50) @(negedge clk);
    chk("pause_cnt_before", 32'(dut.cnt), 32'd51);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    chk("pause_pwm", 32'(pwm_out), 32'd0);
    chk("pause_tick", 32'(period_tick), 32'd0);
    press(4'b0001, 4'b0000);
    inc_duty[1] = 1'b1;
    repeat (90) @(negedge clk);
    chk("pause_cnt_frozen", 32'(dut.cnt), 32'd51);
    chk("pause_pwm_late", 32'(pwm_out), 32'd0);
    ena = 1'b1;
    repeat (10) @(negedge clk);
    chk("resume_cnt", 32'(dut.cnt), 32'd61);
    chk("pause_press_ignored", 32'(dut.duty_shadow[0]), 32'd0);
    chk("resume_no_false_edge", 32'(dut.duty_shadow[1]), 32'd144);
    inc_duty[1] = 1'b0;

    // Asynchronous reset mid-period
    chk("pre_rst_pwm2", 32'(pwm_out[2]), 32'd1);
    center_mode = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(pwm_out), 32'd0);
    chk("async_rst_shadow1", 32'(dut.duty_shadow[1]), 32'd128);
    chk("async_rst_act2", 32'(dut.duty_act[2]), 32'd128);
    chk("async_rst_mode", 32'(dut.mode_act), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    measure();
    chk("post_rst_len", 32'(m_len), 32'd256);
    for (int i = 0; i < 4; i++) chk("post_rst_hi", 32'(m_hi[i]), 32'd128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
